// File: rtl/mips_lite_pkg.sv
// Shared definitions for the mips-lite pipeline: opcode constants, ALU operation
// encoding and instruction field offset helpers.
package mips_lite_pkg;

   localparam logic [3:0] OP_MEM     = 4'b1110;  // LOAD/STORE, selected by the bit below the opcode
   localparam logic [3:0] OP_ILLEGAL = 4'b1111;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4,
      ALU_SLT = 3'd5,
      ALU_SLL = 3'd6,
      ALU_SRL = 3'd7
   } alu_op_e;

   function automatic int op_msb(input int instr_w);
      return instr_w - 1;
   endfunction

   function automatic int mem_load_bit(input int instr_w);
      return instr_w - 5;
   endfunction

   function automatic int rd_lsb(input int ra_w);
      return 2 * ra_w;
   endfunction

   function automatic int mid_lsb(input int ra_w);
      return ra_w;
   endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set on issue,
// cleared by writeback or by flushing the issuing entry.
module reg_scoreboard
   import mips_lite_pkg::*;
#(
   parameter int RA_W = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            set_en,
   input  logic [RA_W-1:0] set_idx,
   input  logic            clr_en,
   input  logic [RA_W-1:0] clr_idx,
   input  logic            fclr_en,
   input  logic [RA_W-1:0] fclr_idx,
   input  logic [RA_W-1:0] q_rs_idx,
   input  logic [RA_W-1:0] q_rt_idx,
   input  logic [RA_W-1:0] q_rd_idx,
   output logic            q_rs,
   output logic            q_rt,
   output logic            q_rd
);

   logic [2**RA_W-1:0] pending;
   logic [2**RA_W-1:0] pending_nxt;

   // NOTE: default first so every path assigns pending_nxt; no latch is inferred.
   always_comb begin
      pending_nxt = pending;
      if (clr_en)  pending_nxt[clr_idx]  = 1'b0;
      if (fclr_en) pending_nxt[fclr_idx] = 1'b0;
      // Applied last: a set beats a clear of the same register on the same edge.
      if (set_en)  pending_nxt[set_idx]  = 1'b1;
   end

   // NOTE: state uses non-blocking assignment; blocking here would race other flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pending <= '0;
      else        pending <= pending_nxt;
   end

   assign q_rs = pending[q_rs_idx];
   assign q_rt = pending[q_rt_idx];
   assign q_rd = pending[q_rd_idx];

endmodule

// File: rtl/instr_decode_pipe.sv
// Single-stage instruction decoder with valid/ready handshakes and a register
// scoreboard that stalls issue on read-after-write and write-after-write hazards.
module instr_decode_pipe
   import mips_lite_pkg::*;
#(
   parameter int INSTR_W = 16,
   parameter int RA_W    = 3,
   parameter int ADDR_W  = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] instr,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2:0]         alu_op,
   output logic               alu_src,
   output logic               reg_write,
   output logic               mem_write,
   output logic               reg_src,
   output logic [RA_W-1:0]    rs,
   output logic [RA_W-1:0]    rt,
   output logic [RA_W-1:0]    rd,
   output logic [RA_W-1:0]    imm,
   output logic [ADDR_W-1:0]  addr,
   output logic               illegal,
   input  logic               wb_valid,
   input  logic [RA_W-1:0]    wb_rd,
   input  logic               flush
);

   localparam int OP_MSB   = op_msb(INSTR_W);
   localparam int LOAD_BIT = mem_load_bit(INSTR_W);
   localparam int RD_LSB   = rd_lsb(RA_W);
   localparam int MID_LSB  = mid_lsb(RA_W);

   typedef struct packed {
      logic [2:0]        alu_op;
      logic              alu_src;
      logic              reg_write;
      logic              mem_write;
      logic              reg_src;
      logic [RA_W-1:0]   rs;
      logic [RA_W-1:0]   rt;
      logic [RA_W-1:0]   rd;
      logic [RA_W-1:0]   imm;
      logic [ADDR_W-1:0] addr;
      logic              illegal;
   } dec_t;

   dec_t       dec, held;
   logic [3:0] op;
   logic       rs_used, rt_used;
   logic       q_rs, q_rt, q_rd;
   logic       hazard, accept;
   logic       unused_instr;

   assign op           = instr[OP_MSB -: 4];
   assign unused_instr = ^instr[LOAD_BIT-1:3*RA_W];

   always_comb begin
      dec     = '0;
      rs_used = 1'b0;
      rt_used = 1'b0;
      if (op == OP_ILLEGAL) begin
         dec.illegal = 1'b1;
      end else if (op == OP_MEM) begin
         dec.alu_op  = ALU_ADD;
         dec.alu_src = 1'b1;
         dec.addr    = instr[MID_LSB +: ADDR_W];
         if (instr[LOAD_BIT]) begin
            dec.rd        = instr[0 +: RA_W];
            dec.reg_write = 1'b1;
            dec.reg_src   = 1'b1;
         end else begin
            dec.rt        = instr[0 +: RA_W];
            dec.mem_write = 1'b1;
            rt_used       = 1'b1;
         end
      end else begin
         dec.alu_op    = op[3:1];
         dec.reg_write = 1'b1;
         dec.rd        = instr[RD_LSB +: RA_W];
         rs_used       = 1'b1;
         if (op[0]) begin
            dec.alu_src = 1'b1;
            dec.imm     = instr[MID_LSB +: RA_W];
            dec.rs      = instr[0 +: RA_W];
         end else begin
            dec.rs  = instr[MID_LSB +: RA_W];
            dec.rt  = instr[0 +: RA_W];
            rt_used = 1'b1;
         end
      end
   end

   reg_scoreboard #(.RA_W(RA_W)) u_scoreboard (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_en   (accept && dec.reg_write),
      .set_idx  (dec.rd),
      .clr_en   (wb_valid),
      .clr_idx  (wb_rd),
      .fclr_en  (flush && out_valid && held.reg_write),
      .fclr_idx (held.rd),
      .q_rs_idx (dec.rs),
      .q_rt_idx (dec.rt),
      .q_rd_idx (dec.rd),
      .q_rs     (q_rs),
      .q_rt     (q_rt),
      .q_rd     (q_rd)
   );

   // Destination is checked too, so two in-flight writes to one register never coexist.
   assign hazard   = (rs_used && q_rs) || (rt_used && q_rt) || (dec.reg_write && q_rd);
   assign in_ready = rst_n && (!out_valid || out_ready) && !hazard && !flush;
   assign accept   = in_valid && in_ready;

   // NOTE: only the output register and scoreboard need reset; decoded fields are
   // cleared too so downstream sees zeros while in reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         held      <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         held      <= dec;
      end else if (flush || out_ready) begin
         out_valid <= 1'b0;
      end
   end

   assign alu_op    = held.alu_op;
   assign alu_src   = held.alu_src;
   assign reg_write = held.reg_write;
   assign mem_write = held.mem_write;
   assign reg_src   = held.reg_src;
   assign rs        = held.rs;
   assign rt        = held.rt;
   assign rd        = held.rd;
   assign imm       = held.imm;
   assign addr      = held.addr;
   assign illegal   = held.illegal;

endmodule

// File: doc/instr_decode_pipe.md
INSTR_DECODE_PIPE -- requirements
Module: instr_decode_pipe

Interface
REQ-001 SHALL have parameter INSTR_W, default 16, instruction width.
REQ-002 SHALL have parameter RA_W, default 3, register-address width; register count is 2**RA_W.
REQ-003 SHALL have parameter ADDR_W, default 6, memory-address field width.
REQ-004 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have ports in_valid (input, 1), in_ready (output, 1), instr (input, INSTR_W): the fetch-side handshake.
REQ-007 SHALL have ports out_valid (output, 1) and out_ready (input, 1): the execute-side handshake.
REQ-008 SHALL have registered outputs alu_op (3), alu_src (1), reg_write (1), mem_write (1), reg_src (1), rs/rt/rd (RA_W each), imm (RA_W), addr (ADDR_W), illegal (1).
REQ-009 SHALL have ports wb_valid (input, 1) and wb_rd (input, RA_W): the writeback completion that clears a pending register.
REQ-010 SHALL have port flush (input, 1), which discards the held output entry.

Function
REQ-011 SHALL decode op=instr[INSTR_W-1:INSTR_W-4]; op[3:1]=alu_op and op[0]=immediate, for op 0000..1101.
REQ-012 SHALL decode R-type (op[0]=0) as rd=[3RA_W-1:2RA_W], rs=[2RA_W-1:RA_W], rt=[RA_W-1:0]; alu_src=0.
REQ-013 SHALL decode I-type (op[0]=1) as rd=[3RA_W-1:2RA_W], imm=[2RA_W-1:RA_W], rs=[RA_W-1:0]; alu_src=1.
REQ-014 SHALL treat op=1110 as a memory op: instr[INSTR_W-5]=1 is LOAD, 0 is STORE; addr=[ADDR_W+RA_W-1:RA_W]; reg field=[RA_W-1:0]; alu_op=000; alu_src=1.
REQ-015 SHALL route the LOAD reg field to rd with reg_write=1 and reg_src=1, and the STORE reg field to rt with mem_write=1 and reg_write=0.
REQ-016 SHALL route ALU ops with reg_write=1, mem_write=0 and reg_src=0.
REQ-017 SHALL treat op=1111 as illegal: illegal=1, with reg_write and mem_write forced to 0.
REQ-018 SHALL zero every field an instruction class does not use.
REQ-019 SHALL have one output register stage: an instruction accepted on edge N is presented with out_valid=1 after edge N.
REQ-020 SHALL accept an instruction when in_valid&&in_ready; SHALL hold the outputs stable while out_valid&&!out_ready.
REQ-021 SHALL drive in_ready = (!out_valid||out_ready) && !hazard && !flush, with no combinational path from in_valid.
REQ-022 SHALL keep a scoreboard of 2**RA_W pending bits and set pending[rd] when an instruction with reg_write=1 is accepted.
REQ-023 SHALL clear pending[wb_rd] on wb_valid; if a set and a clear hit the same register on the same edge, the set wins.
REQ-024 SHALL raise hazard when any source register used (rs, plus rt for R-type/STORE) or the destination rd is pending, using registered scoreboard state only.
REQ-025 SHALL, on flush, clear out_valid next edge, clear pending[rd] of the flushed entry if it had reg_write, and accept no input that cycle.
REQ-026 SHALL, on a flush with out_valid=0, change only in_ready.

Reset
REQ-027 SHALL, while rst_n=0, immediately force out_valid=0, all decoded outputs=0, illegal=0 and every pending bit=0.
REQ-028 SHALL drive in_ready=0 during reset and SHALL operate from the first clk edge after rst_n rises; any entry in flight at reset is lost.

Structure
REQ-029 SHALL take opcode constants (LOAD/STORE=1110, ILLEGAL=1111), the alu_op encoding and field-offset functions from shared package mips_lite_pkg.
REQ-030 SHALL implement the scoreboard as sub-module reg_scoreboard (set, clear, flush-clear and per-register query ports).

Verification
REQ-031 SHALL check: instr=16'h0993 accepted -> next cycle alu_op=000, alu_src=0, reg_write=1, rd=6, rs=2, rt=3, pending[6]=1.
REQ-032 SHALL check: 16'h0993 then 16'h2171 (SUB $5 $6 $1) -> in_ready=0 until wb_valid/wb_rd=6; SUB accepted the edge after the clear.
REQ-033 SHALL check: 16'h1955 with out_ready=0 for 3 cycles -> outputs held stable (imm=2, rs=5, rd=5, alu_src=1); in_ready=0; released when out_ready=1.
REQ-034 SHALL check: 16'hE4B2 -> mem_write=1, reg_write=0, rt=2; and 16'hF000 -> illegal=1, reg_write=0, mem_write=0, no pending bit set.
REQ-035 SHALL check: flush while 16'h0993 held -> out_valid=0 next cycle and pending[6]=0.
REQ-036 SHALL check: rst_n low mid-stall -> out_valid=0 and pending bits cleared without a clock edge.
